// File: rtl/counter_cmd_sched.sv
// rtl/counter_cmd_sched.sv - round-robin command scheduler driving the 16-bit up/down counter
module counter_cmd_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NREQ-1:0]       rq_valid,
  input  logic [2*NREQ-1:0]     rq_op,
  input  logic [WIDTH*NREQ-1:0] rq_arg,
  output logic [NREQ-1:0]       rq_ready,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  wrap,
  output logic                  busy,
  output logic                  ld_cnt,
  output logic                  updn_cnt,
  output logic                  count_enb,
  output logic [WIDTH-1:0]      cnt_data_in,
  input  logic [WIDTH-1:0]      cnt_data_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    id_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] arg_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] remain;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;
  logic [PW:0]      sum;
  logic             found;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_arg;
  logic [WIDTH:0]   up_sum;
  logic             wrap_calc;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!found && rq_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    rq_ready = '0;
    if (rst_ && state == S_IDLE && found) rq_ready[win] = 1'b1;
  end

  assign sel_op    = rq_op[2*win +: 2];
  assign sel_arg   = rq_arg[WIDTH*win +: WIDTH];
  assign up_sum    = {1'b0, start_q} + {1'b0, arg_q};
  assign wrap_calc = (op_q == OP_UP)   ? up_sum[WIDTH] :
                     (op_q == OP_DOWN) ? (arg_q > start_q) : 1'b0;
  assign result    = (done != '0) ? cnt_data_out : '0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      id_q        <= '0;
      op_q        <= OP_LOAD;
      arg_q       <= '0;
      start_q     <= '0;
      remain      <= '0;
      ld_cnt      <= 1'b1;
      updn_cnt    <= 1'b0;
      count_enb   <= 1'b0;
      cnt_data_in <= '0;
      done        <= '0;
      wrap        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            id_q    <= win;
            op_q    <= sel_op;
            arg_q   <= sel_arg;
            start_q <= cnt_data_out;
            remain  <= sel_arg;
            rr_ptr  <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
            busy    <= 1'b1;
            state   <= S_EXEC;
            case (sel_op)
              OP_LOAD: begin
                ld_cnt      <= 1'b0;
                cnt_data_in <= sel_arg;
              end
              OP_CLEAR: begin
                ld_cnt      <= 1'b0;
                cnt_data_in <= '0;
              end
              default: begin
                updn_cnt  <= (sel_op == OP_UP);
                count_enb <= (sel_arg != '0);
              end
            endcase
          end
        end
        S_EXEC: begin
          // remain counts enabled cycles still owed; n==0 leaves after one idle cycle.
          if (op_q == OP_LOAD || op_q == OP_CLEAR || remain <= WIDTH'(1)) begin
            ld_cnt    <= 1'b1;
            count_enb <= 1'b0;
            done      <= NREQ'(1) << id_q;
            wrap      <= wrap_calc;
            state     <= S_DONE;
          end else begin
            remain <= remain - 1'b1;
          end
        end
        S_DONE: begin
          done  <= '0;
          wrap  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_sched.sv
// tb/tb_counter_cmd_sched.sv - self-checking bench for counter_cmd_sched with counter model
module tb_counter_cmd_sched;
  localparam int NREQ = 2;
  localparam int WIDTH = 16;
  localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic [NREQ-1:0] rq_valid;
  logic [2*NREQ-1:0] rq_op;
  logic [WIDTH*NREQ-1:0] rq_arg;
  logic [NREQ-1:0] rq_ready, done;
  logic [WIDTH-1:0] result, cnt_data_in, cnt_data_out;
  logic wrap, busy, ld_cnt, updn_cnt, count_enb;

  always #5 clk = ~clk;

  counter_cmd_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_(rst_), .rq_valid(rq_valid), .rq_op(rq_op), .rq_arg(rq_arg),
    .rq_ready(rq_ready), .done(done), .result(result), .wrap(wrap), .busy(busy),
    .ld_cnt(ld_cnt), .updn_cnt(updn_cnt), .count_enb(count_enb),
    .cnt_data_in(cnt_data_in), .cnt_data_out(cnt_data_out)
  );

  // The counter the scheduler drives.
  logic [15:0] cnt;
  always @(posedge clk or negedge rst_) begin
    if (!rst_) cnt <= 16'h0;
    else if (!ld_cnt) cnt <= cnt_data_in;
    else if (count_enb) cnt <= updn_cnt ? cnt + 16'd1 : cnt - 16'd1;
  end
  assign cnt_data_out = cnt;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int enb_total = 0, ld_total = 0;
  always @(negedge clk) begin
    if (rst_ && count_enb) enb_total++;
    if (rst_ && !ld_cnt) ld_total++;
  end

  int nchk = 0, nerr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Command-level model: one outstanding command with its timeline and outcome.
  bit pend = 0;
  int m_id, m_op, m_arg, m_start, m_res, ac, dc, mptr = 0, mcnt = 0, w;
  bit m_wrap, exp_ld, exp_enb;
  logic [NREQ-1:0] er;

  always @(negedge clk) begin
    if (!rst_) begin
      pend = 0; mptr = 0; mcnt = 0;
      chk("rst_ld_cnt", ld_cnt, 1); chk("rst_count_enb", count_enb, 0);
      chk("rst_rq_ready", rq_ready, 0); chk("rst_busy", busy, 0);
      chk("rst_done", done, 0); chk("rst_wrap", wrap, 0);
      chk("rst_result", result, 0); chk("rst_counter", cnt, 0);
    end else begin
      er = '0;
      if (!pend)
        for (int k = 0; k < NREQ; k++) begin
          w = (mptr + k) % NREQ;
          if (er == 0 && rq_valid[w]) er[w] = 1'b1;
        end
      chk("rq_ready", rq_ready, er);
      if (pend) begin
        exp_ld  = !((m_op == LOAD || m_op == CLEAR) && cyc == ac + 1);
        exp_enb = (m_op == UP || m_op == DOWN) && cyc <= ac + m_arg;
        chk("busy", busy, 1);
        chk("done", done, (cyc == dc) ? (1 << m_id) : 0);
        chk("ld_cnt", ld_cnt, exp_ld);
        if (!exp_ld) chk("cnt_data_in", cnt_data_in, (m_op == LOAD) ? m_arg : 0);
        chk("count_enb", count_enb, exp_enb);
        if (exp_enb) chk("updn_cnt", updn_cnt, m_op == UP);
        if (cyc == dc) begin
          chk("result", result, m_res);
          chk("wrap", wrap, m_wrap);
          mcnt = m_res;
          pend = 0;
        end
      end else begin
        chk("idle_busy", busy, 0); chk("idle_done", done, 0);
        chk("idle_ld_cnt", ld_cnt, 1); chk("idle_count_enb", count_enb, 0);
      end
      if (er != 0) begin
        m_id = er[1] ? 1 : 0;
        m_op = int'(rq_op[2*m_id +: 2]);
        m_arg = int'(rq_arg[16*m_id +: 16]);
        m_start = mcnt; ac = cyc;
        case (m_op)
          LOAD:    begin m_res = m_arg; m_wrap = 0; end
          CLEAR:   begin m_res = 0; m_wrap = 0; end
          UP:      begin m_res = (m_start + m_arg) % 65536; m_wrap = (m_start + m_arg) >= 65536; end
          default: begin m_res = (m_start - m_arg + 65536) % 65536; m_wrap = m_arg > m_start; end
        endcase
        dc = (m_op == LOAD || m_op == CLEAR || m_arg == 0) ? cyc + 2 : cyc + m_arg + 1;
        mptr = (m_id + 1) % NREQ;
        pend = 1;
      end
    end
  end

  task automatic start_req(input int id, input logic [1:0] op, input logic [15:0] arg);
    @(posedge clk); #1;
    rq_op[2*id +: 2] = op; rq_arg[16*id +: 16] = arg; rq_valid[id] = 1'b1;
  endtask

  task automatic wait_acc(input int id, output int a, output int e0, output int l0);
    bit got = 0;
    a = 0; e0 = 0; l0 = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (rq_ready[id]) begin got = 1; a = cyc; e0 = enb_total; l0 = ld_total; end
    end
    if (!got) begin nchk++; nerr++; $display("FAIL accept_timeout: req %0d never accepted", id); end
    @(posedge clk); #1 rq_valid[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, input int a, input int e0, input int l0,
                           output logic [15:0] r, output logic wr, output int lat,
                           output int enb, output int ldc);
    bit got = 0;
    r = 0; wr = 0; lat = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (done[id]) begin got = 1; r = result; wr = wrap; lat = cyc - a; end
    end
    if (!got) begin nchk++; nerr++; $display("FAIL done_timeout: req %0d never done", id); end
    enb = enb_total - e0; ldc = ld_total - l0;
  endtask

  logic [15:0] res;
  logic wr;
  int lat, enb, ldc, a, e0, l0, nacc;
  int acc[$];

  task automatic issue(input int id, input logic [1:0] op, input logic [15:0] arg);
    start_req(id, op, arg);
    wait_acc(id, a, e0, l0);
    wait_done(id, a, e0, l0, res, wr, lat, enb, ldc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rq_valid = '0; rq_op = '0; rq_arg = '0;
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b1;

    issue(0, LOAD, 16'h1234);
    chk("t2_result", res, 16'h1234); chk("t2_wrap", wr, 0);
    chk("t2_latency", lat, 2); chk("t2_ld_low_cycles", ldc, 1);

    issue(0, LOAD, 16'hFFFE);
    issue(1, UP, 16'd3);
    chk("t3_result", res, 16'h0001); chk("t3_wrap", wr, 1);
    chk("t3_enb_cycles", enb, 3); chk("t3_latency", lat, 4);

    issue(0, LOAD, 16'h0002);
    issue(1, DOWN, 16'd2);
    chk("t4a_result", res, 16'h0000); chk("t4a_wrap", wr, 0); chk("t4a_latency", lat, 3);
    issue(0, LOAD, 16'h0002);
    issue(1, DOWN, 16'd3);
    chk("t4b_result", res, 16'hFFFF); chk("t4b_wrap", wr, 1); chk("t4b_enb_cycles", enb, 3);

    issue(0, UP, 16'd0);
    chk("t6_result", res, 16'hFFFF); chk("t6_wrap", wr, 0);
    chk("t6_enb_cycles", enb, 0); chk("t6_latency", lat, 2);

    issue(1, CLEAR, 16'h5555);
    chk("clr_result", res, 16'h0000); chk("clr_latency", lat, 2);

    issue(0, LOAD, 16'h0005);
    issue(0, DOWN, 16'd5);
    chk("down_eq_result", res, 16'h0000); chk("down_eq_wrap", wr, 0);
    issue(1, LOAD, 16'hFFFD);
    issue(1, UP, 16'd2);
    chk("up_to_max_result", res, 16'hFFFF); chk("up_to_max_wrap", wr, 0);

    // Withdrawn request while busy, then a request whose arg changes before it is accepted.
    issue(0, LOAD, 16'hFFFC);
    start_req(0, UP, 16'd6);
    wait_acc(0, a, e0, l0);
    rq_op[3:2] = LOAD; rq_arg[31:16] = 16'hAAAA; rq_valid[1] = 1'b1;
    @(posedge clk); #1 rq_valid[1] = 1'b0;
    @(posedge clk); #1 rq_valid[1] = 1'b1; rq_arg[31:16] = 16'h0BEE;
    @(posedge clk); #1 rq_arg[31:16] = 16'h0BEF;
    wait_done(0, a, e0, l0, res, wr, lat, enb, ldc);
    chk("wd_up_result", res, 16'h0002); chk("wd_up_wrap", wr, 1); chk("wd_up_latency", lat, 7);
    wait_acc(1, a, e0, l0);
    wait_done(1, a, e0, l0, res, wr, lat, enb, ldc);
    chk("late_arg_result", res, 16'h0BEF);

    // Reset during an UP run with both requesters asserting valid.
    issue(0, LOAD, 16'h0100);
    start_req(0, UP, 16'd20);
    wait_acc(0, a, e0, l0);
    repeat (5) @(posedge clk);
    #3 rst_ = 1'b0; rq_valid = 2'b11;
    @(negedge clk);
    chk("t1_ld_cnt", ld_cnt, 1); chk("t1_count_enb", count_enb, 0);
    chk("t1_rq_ready", rq_ready, 0); chk("t1_busy", busy, 0);
    chk("t1_done", done, 0); chk("t1_counter", cnt, 0);
    @(posedge clk); #1 rst_ = 1'b1; rq_valid = 2'b00;
    repeat (2) @(posedge clk);

    // Round-robin fairness from a fresh reset.
    #1 rst_ = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
    rq_op = {UP, UP}; rq_arg = {16'd1, 16'd1}; rq_valid = 2'b11;
    nacc = 0;
    for (int k = 0; k < 100 && nacc < 4; k++) begin
      @(negedge clk);
      if ((rq_valid & rq_ready) != 0) begin acc.push_back(rq_ready[1] ? 1 : 0); nacc++; end
    end
    @(posedge clk); #1 rq_valid = 2'b00;
    chk("rr_accepts", nacc, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order_%0d", i), (i < acc.size()) ? acc[i] : 9, i % 2);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rr_final_counter", cnt, 16'd4);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
